conv_layer_sequencer: RTL

- Parametrised successor to the single-layer conv controller FSM.
- Sequences one convolution layer with configurable stride, padding, kernel and filter count:
  - prefetch address generation;
  - issue of one MAC operation per output point, in ch_out, y, x loop order with x fastest;
  - a coordinate-tracking pipeline that tags each result when it leaves a MAC of fixed latency;
  - pipeline drain and a done pulse.
- Sits between the top-level start handshake and the memory/MAC datapath.
- Adds operand-stall support, input-window origin output, and a drain state.

---
 rtl/conv_layer_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: sequences one convolution layer.
// The layer runs in four phases: prefetch, MAC issue in ch/y/x order, pipeline drain, then a done pulse.
// A fixed-latency tag pipeline labels each MAC result with its output coordinates as it leaves the MAC.
// Optional feature: define CONV_SEQ_STALL_COUNTER_EN to add the stall_cycles counter port.
module conv_layer_sequencer #(
  parameter int ACT_SIZE          = 64,
  parameter int KERNEL_SIZE       = 3,
  parameter int PADDING           = 1,
  parameter int STRIDE            = 1,
  parameter int NUM_FILTERS       = 32,
  parameter int MAC_LATENCY       = 7,
  parameter int PREFETCH_WORDS    = 256,
  parameter int MEM_ADDRESS_WIDTH = 20,
  localparam int OUT_SIZE = (ACT_SIZE + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int CW       = ($clog2(OUT_SIZE) < 1) ? 1 : $clog2(OUT_SIZE),
  localparam int FW       = ($clog2(NUM_FILTERS) < 1) ? 1 : $clog2(NUM_FILTERS),
  localparam int OW       = $clog2(ACT_SIZE + PADDING) + 2
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic                         start,
  input  logic                         stall_in,
  output logic                         running,
  output logic                         done,
  output logic                         mem_re,
  output logic [MEM_ADDRESS_WIDTH-1:0] mem_read_addr,
  output logic                         mac_valid,
  output logic signed [OW-1:0]         win_x,
  output logic signed [OW-1:0]         win_y,
  output logic                         output_valid,
  output logic [CW-1:0]                output_x,
  output logic [CW-1:0]                output_y,
  output logic [FW-1:0]                output_ch
`ifdef CONV_SEQ_STALL_COUNTER_EN
  , output logic [31:0]                stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, PREFETCH, COMPUTE, DRAIN} state_t;

  state_t state, state_next;

  logic [MEM_ADDRESS_WIDTH-1:0] pf_addr;
  logic [CW-1:0]                x_cnt, y_cnt;
  logic [FW-1:0]                ch_cnt;

  logic          pipe_valid [MAC_LATENCY];
  logic [CW-1:0] pipe_x     [MAC_LATENCY];
  logic [CW-1:0] pipe_y     [MAC_LATENCY];
  logic [FW-1:0] pipe_ch    [MAC_LATENCY];

  logic pf_last, x_last, y_last, ch_last, layer_last, pipe_busy;
  logic signed [OW-1:0] origin_x, origin_y;

  assign pf_last    = (pf_addr == MEM_ADDRESS_WIDTH'(PREFETCH_WORDS - 1));
  assign x_last     = (x_cnt == CW'(OUT_SIZE - 1));
  assign y_last     = (y_cnt == CW'(OUT_SIZE - 1));
  assign ch_last    = (ch_cnt == FW'(NUM_FILTERS - 1));
  assign layer_last = x_last && y_last && ch_last;

  // The window origin may go negative at padded borders, so it is computed in signed arithmetic.
  assign origin_x = OW'(int'(x_cnt) * STRIDE - PADDING);
  assign origin_y = OW'(int'(y_cnt) * STRIDE - PADDING);

  // State register; reset aborts any layer in progress without a done pulse.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state and phase outputs; outputs read zero outside their own phase.
  always_comb begin
    state_next    = state;
    running       = 1'b0;
    done          = 1'b0;
    mem_re        = 1'b0;
    mem_read_addr = '0;
    mac_valid     = 1'b0;
    win_x         = '0;
    win_y         = '0;
    case (state)
      IDLE: begin
        if (start) state_next = PREFETCH;
      end
      PREFETCH: begin
        running       = 1'b1;
        mem_re        = 1'b1;
        mem_read_addr = pf_addr;
        if (pf_last) state_next = COMPUTE;
      end
      COMPUTE: begin
        running   = 1'b1;
        mac_valid = !stall_in;
        win_x     = origin_x;
        win_y     = origin_y;
        if (!stall_in && layer_last) state_next = DRAIN;
      end
      DRAIN: begin
        running = 1'b1;
        if (!pipe_busy) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The last stage leaves the MAC this cycle, so only earlier stages keep the drain alive.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < MAC_LATENCY - 1; i++) pipe_busy = pipe_busy | pipe_valid[i];
  end

  // Prefetch address and output-point loop counters, x fastest, wrapping to 0 after the last point.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      pf_addr <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      ch_cnt  <= '0;
    end else if (state == IDLE && start) begin
      pf_addr <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      ch_cnt  <= '0;
    end else if (state == PREFETCH) begin
      pf_addr <= pf_addr + MEM_ADDRESS_WIDTH'(1);
    end else if (mac_valid) begin
      if (x_last) begin
        x_cnt <= '0;
        if (y_last) begin
          y_cnt  <= '0;
          ch_cnt <= ch_last ? '0 : ch_cnt + FW'(1);
        end else begin
          y_cnt <= y_cnt + CW'(1);
        end
      end else begin
        x_cnt <= x_cnt + CW'(1);
      end
    end
  end

  // Coordinate tag pipeline shifts every cycle; stalls enter it as bubbles.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < MAC_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_x[i]     <= '0;
        pipe_y[i]     <= '0;
        pipe_ch[i]    <= '0;
      end
    end else begin
      pipe_valid[0] <= mac_valid;
      pipe_x[0]     <= x_cnt;
      pipe_y[0]     <= y_cnt;
      pipe_ch[0]    <= ch_cnt;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_x[i]     <= pipe_x[i-1];
        pipe_y[i]     <= pipe_y[i-1];
        pipe_ch[i]    <= pipe_ch[i-1];
      end
    end
  end

  assign output_valid = pipe_valid[MAC_LATENCY-1];
  assign output_x     = output_valid ? pipe_x[MAC_LATENCY-1]  : '0;
  assign output_y     = output_valid ? pipe_y[MAC_LATENCY-1]  : '0;
  assign output_ch    = output_valid ? pipe_ch[MAC_LATENCY-1] : '0;

`ifdef CONV_SEQ_STALL_COUNTER_EN
  // Saturating count of stalled COMPUTE cycles; restarts with each layer and holds afterwards.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)                                       stall_cycles <= '0;
    else if (state == IDLE && start)                      stall_cycles <= '0;
    else if (state == COMPUTE && stall_in && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`else
  // Without the counter, a stall only holds the loop counters and inserts a pipeline bubble.
`endif

endmodule
